ysyx_040729_trap_ctrl: RTL and testbench

Parametrised machine-mode trap controller; successor to the combinational exception cause encoder. Synchronises N external interrupt lines plus timer/software interrupts, and prioritises them against synchronous exceptions (ecall, ebreak, illegal instruction) at instruction boundaries. Sequences trap entry and mret through a handshaked flush/CSR-write/redirect FSM. Sits between the commit stage, the CSR file and the fetch redirect path.

---
 rtl/ysyx_040729_trap_pkg.sv | 31 +++
 rtl/ysyx_040729_irq_sync.sv | 26 ++
 rtl/ysyx_040729_trap_ctrl.sv | 158 +++++++++++++++
 tb/tb_ysyx_040729_trap_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_040729_trap_pkg.sv
// Shared definitions for the machine-mode trap controller: cause codes,
// FSM encoding, mtvec modes and a priority helper.
package ysyx_040729_trap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_CSRW  = 2'd2,
      ST_REDIR = 2'd3
   } trap_state_e;

   localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
   localparam logic [3:0] CAUSE_BREAK   = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
   localparam logic [3:0] CAUSE_MSI     = 4'd3;
   localparam logic [3:0] CAUSE_MTI     = 4'd7;
   localparam logic [3:0] CAUSE_MEI     = 4'd11;

   localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
   localparam logic [1:0] MTVEC_VECTORED = 2'd1;

   // Index of the lowest set bit (bit 0 wins); 0 when nothing is set.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (v[i]) idx = 4'(i);
      return idx;
   endfunction

endpackage

// File: rtl/ysyx_040729_irq_sync.sv
// Multi-flop synchroniser for asynchronous level interrupt lines.
module ysyx_040729_irq_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff <= '0;
      end else begin
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++)
            ff[i] <= ff[i-1];
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/ysyx_040729_trap_ctrl.sv
// Machine-mode trap controller: prioritises interrupts against synchronous
// exceptions at commit and sequences flush -> CSR write -> fetch redirect.
module ysyx_040729_trap_ctrl
   import ysyx_040729_trap_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int NUM_EXT     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_EXT-1:0]    ext_irq,
   input  logic                  tmr_irq,
   input  logic                  sw_irq,
   input  logic                  mstatus_mie,
   input  logic [2:0]            mie_bits,
   input  logic                  commit_valid,
   input  logic [DATA_WIDTH-1:0] commit_pc,
   input  logic                  ecall,
   input  logic                  ebreak,
   input  logic                  illegal,
   input  logic [31:0]           illegal_inst,
   input  logic                  mret,
   input  logic [DATA_WIDTH-1:0] mtvec,
   input  logic [DATA_WIDTH-1:0] mepc_in,
   output logic                  busy,
   output logic                  flush_req,
   input  logic                  flush_ack,
   output logic                  csr_we,
   output logic                  csr_is_mret,
   output logic [DATA_WIDTH-1:0] trap_mcause,
   output logic [DATA_WIDTH-1:0] trap_mepc,
   output logic [DATA_WIDTH-1:0] trap_mtval,
   output logic [3:0]            ext_id,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  redirect_ready,
   output logic [2:0]            mip
);

   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

   trap_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] cause_q, cause_d;
   logic [DATA_WIDTH-1:0] epc_q, epc_d;
   logic [DATA_WIDTH-1:0] tval_q, tval_d;
   logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
   logic [3:0]            ext_id_q, ext_id_d;
   logic                  mret_q, mret_d;

   logic [NUM_EXT-1:0]    ext_sync;
   logic [2:0]            irq_en;
   logic [3:0]            code;
   logic [DATA_WIDTH-1:0] tvec_base;

   ysyx_040729_irq_sync #(
      .WIDTH (NUM_EXT),
      .STAGES(SYNC_STAGES)
   ) u_irq_sync (
      .clk(clk),
      .rst(rst),
      .d  (ext_irq),
      .q  (ext_sync)
   );

   // tmr/sw are already synchronous, so only MEIP carries the sync latency.
   assign mip       = {|ext_sync, tmr_irq, sw_irq};
   assign irq_en    = mip & mie_bits & {3{mstatus_mie}};
   assign tvec_base = mtvec & ALIGN_MASK;

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      tval_d   = tval_q;
      tgt_d    = tgt_q;
      ext_id_d = ext_id_q;
      mret_d   = mret_q;
      code     = CAUSE_MTI;
      if (irq_en[2])      code = CAUSE_MEI;
      else if (irq_en[0]) code = CAUSE_MSI;

      case (state_q)
         ST_IDLE: begin
            if (commit_valid) begin
               if (|irq_en) begin
                  state_d  = ST_FLUSH;
                  mret_d   = 1'b0;
                  cause_d  = {1'b1, {(DATA_WIDTH-5){1'b0}}, code};
                  epc_d    = commit_pc;
                  tval_d   = '0;
                  ext_id_d = irq_en[2] ? lowest_set(16'(ext_sync)) : 4'd0;
                  // Modes 2/3 fall back to direct.
                  tgt_d    = (mtvec[1:0] == MTVEC_VECTORED)
                           ? tvec_base + (DATA_WIDTH'(code) << 2) : tvec_base;
               end else if (illegal || ebreak || ecall) begin
                  state_d  = ST_FLUSH;
                  mret_d   = 1'b0;
                  epc_d    = commit_pc;
                  ext_id_d = 4'd0;
                  tgt_d    = tvec_base;
                  if (illegal) begin
                     cause_d = DATA_WIDTH'(CAUSE_ILLEGAL);
                     tval_d  = DATA_WIDTH'(illegal_inst);
                  end else if (ebreak) begin
                     cause_d = DATA_WIDTH'(CAUSE_BREAK);
                     tval_d  = commit_pc;
                  end else begin
                     cause_d = DATA_WIDTH'(CAUSE_ECALL_M);
                     tval_d  = '0;
                  end
               end else if (mret) begin
                  state_d  = ST_FLUSH;
                  mret_d   = 1'b1;
                  ext_id_d = 4'd0;
                  tgt_d    = mepc_in & ALIGN_MASK;
               end
            end
         end
         ST_FLUSH: if (flush_ack)      state_d = ST_CSRW;
         ST_CSRW:                      state_d = ST_REDIR;
         ST_REDIR: if (redirect_ready) state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cause_q  <= '0;
         epc_q    <= '0;
         tval_q   <= '0;
         tgt_q    <= '0;
         ext_id_q <= '0;
         mret_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
         tval_q   <= tval_d;
         tgt_q    <= tgt_d;
         ext_id_q <= ext_id_d;
         mret_q   <= mret_d;
      end
   end

   assign busy           = (state_q != ST_IDLE);
   assign flush_req      = (state_q == ST_FLUSH);
   assign csr_we         = (state_q == ST_CSRW);
   assign redirect_valid = (state_q == ST_REDIR);
   assign csr_is_mret    = mret_q;
   assign trap_mcause    = cause_q;
   assign trap_mepc      = epc_q;
   assign trap_mtval     = tval_q;
   assign ext_id         = ext_id_q;
   assign redirect_pc    = tgt_q;

endmodule

// File: tb/tb_ysyx_040729_trap_ctrl.sv
// Directed bench for the trap controller with hand-computed expectations.
module tb_ysyx_040729_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ext_irq;
   logic        tmr_irq, sw_irq, mstatus_mie;
   logic [2:0]  mie_bits;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic        ecall, ebreak, illegal, mret;
   logic [31:0] illegal_inst;
   logic [63:0] mtvec, mepc_in;
   logic        busy, flush_req, flush_ack, csr_we, csr_is_mret;
   logic [63:0] trap_mcause, trap_mepc, trap_mtval, redirect_pc;
   logic [3:0]  ext_id;
   logic        redirect_valid, redirect_ready;
   logic [2:0]  mip;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ysyx_040729_trap_ctrl dut (
      .clk(clk), .rst(rst), .ext_irq(ext_irq), .tmr_irq(tmr_irq), .sw_irq(sw_irq),
      .mstatus_mie(mstatus_mie), .mie_bits(mie_bits), .commit_valid(commit_valid),
      .commit_pc(commit_pc), .ecall(ecall), .ebreak(ebreak), .illegal(illegal),
      .illegal_inst(illegal_inst), .mret(mret), .mtvec(mtvec), .mepc_in(mepc_in),
      .busy(busy), .flush_req(flush_req), .flush_ack(flush_ack), .csr_we(csr_we),
      .csr_is_mret(csr_is_mret), .trap_mcause(trap_mcause), .trap_mepc(trap_mepc),
      .trap_mtval(trap_mtval), .ext_id(ext_id), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .mip(mip)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One-cycle commit; returns at the negedge after the decision edge.
   task automatic commit(input logic [63:0] pc, input logic ec, input logic eb,
                         input logic il, input logic mr, input logic [31:0] inst);
      commit_valid = 1'b1; commit_pc = pc; ecall = ec; ebreak = eb;
      illegal = il; mret = mr; illegal_inst = inst;
      @(negedge clk);
      commit_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0; mret = 1'b0;
   endtask

   task automatic trap_seq(input string tag, input logic [63:0] ecause,
                           input logic [63:0] eepc, input logic [63:0] etval,
                           input logic [63:0] epc_tgt, input logic emret,
                           input logic [3:0] eext, input int ack_wait, input int rdy_wait);
      chk({tag, ".flush_req"}, flush_req, 1);
      chk({tag, ".busy"}, busy, 1);
      for (int i = 0; i < ack_wait; i++) begin
         @(negedge clk);
         chk({tag, ".flush_hold"}, flush_req, 1);
         chk({tag, ".no_csrw"}, csr_we, 0);
      end
      flush_ack = 1'b1;
      @(negedge clk);
      flush_ack = 1'b0;
      chk({tag, ".csr_we"}, csr_we, 1);
      chk({tag, ".flush_drop"}, flush_req, 0);
      chk({tag, ".is_mret"}, csr_is_mret, emret);
      if (!emret) begin
         chk({tag, ".mcause"}, trap_mcause, ecause);
         chk({tag, ".mepc"}, trap_mepc, eepc);
         chk({tag, ".mtval"}, trap_mtval, etval);
         chk({tag, ".ext_id"}, ext_id, eext);
      end
      @(negedge clk);
      chk({tag, ".csr_we_once"}, csr_we, 0);
      chk({tag, ".redir_valid"}, redirect_valid, 1);
      chk({tag, ".redir_pc"}, redirect_pc, epc_tgt);
      for (int i = 0; i < rdy_wait; i++) begin
         @(negedge clk);
         chk({tag, ".redir_hold"}, redirect_valid, 1);
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      chk({tag, ".idle"}, busy, 0);
      chk({tag, ".redir_drop"}, redirect_valid, 0);
   endtask

   initial begin
      rst = 1'b1; ext_irq = '0; tmr_irq = 0; sw_irq = 0; mstatus_mie = 0; mie_bits = '0;
      commit_valid = 0; commit_pc = '0; ecall = 0; ebreak = 0; illegal = 0; mret = 0;
      illegal_inst = '0; mtvec = '0; mepc_in = '0; flush_ack = 0; redirect_ready = 0;
      repeat (3) @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.flush_req", flush_req, 0);
      chk("rst.csr_we", csr_we, 0);
      chk("rst.redir_valid", redirect_valid, 0);
      chk("rst.mcause", trap_mcause, 0);
      chk("rst.redir_pc", redirect_pc, 0);
      chk("rst.mip", mip, 0);
      rst = 1'b0;
      @(negedge clk);

      // flush_ack and redirect_ready in IDLE must do nothing
      flush_ack = 1'b1; redirect_ready = 1'b1;
      @(negedge clk);
      flush_ack = 1'b0; redirect_ready = 1'b0;
      chk("idle_ack.busy", busy, 0);
      chk("idle_ack.csr_we", csr_we, 0);

      // plain commit with no event stays idle
      commit(64'h8000_0000, 0, 0, 0, 0, 32'h0);
      chk("nop.busy", busy, 0);

      // ecall, direct mode
      mtvec = 64'h8000_1000;
      commit(64'h8000_0010, 1, 0, 0, 0, 32'h0);
      trap_seq("ecall", 64'd11, 64'h8000_0010, 64'd0, 64'h8000_1000, 0, 4'd0, 2, 0);

      // external line 2 through the synchroniser, vectored mode
      mstatus_mie = 1; mie_bits = 3'b100; mtvec = 64'h8000_1001; ext_irq = 4'b0100;
      @(negedge clk);
      chk("sync.lat1", mip, 3'b000);
      @(negedge clk);
      chk("sync.lat2", mip, 3'b100);
      commit(64'h8000_0100, 0, 0, 0, 0, 32'h0);
      trap_seq("mei", 64'h8000_0000_0000_000B, 64'h8000_0100, 64'd0,
               64'h8000_102C, 0, 4'd2, 0, 0);
      ext_irq = '0;
      repeat (3) @(negedge clk);
      chk("sync.clear", mip, 3'b000);

      // MSI beats MTI and ecall
      tmr_irq = 1; sw_irq = 1; mie_bits = 3'b111;
      commit(64'h8000_0200, 1, 0, 0, 0, 32'h0);
      trap_seq("msi", 64'h8000_0000_0000_0003, 64'h8000_0200, 64'd0,
               64'h8000_100C, 0, 4'd0, 0, 0);

      // MTI alone, vectored
      sw_irq = 0; mie_bits = 3'b010;
      commit(64'h8000_0204, 0, 0, 0, 0, 32'h0);
      trap_seq("mti", 64'h8000_0000_0000_0007, 64'h8000_0204, 64'd0,
               64'h8000_101C, 0, 4'd0, 1, 1);

      // interrupts globally masked: illegal wins, exceptions ignore vectoring
      sw_irq = 1; mie_bits = 3'b111; mstatus_mie = 0;
      commit(64'h8000_0300, 1, 1, 1, 0, 32'hFFFF_FFFF);
      trap_seq("illegal", 64'd2, 64'h8000_0300, 64'h0000_0000_FFFF_FFFF,
               64'h8000_1000, 0, 4'd0, 0, 0);
      tmr_irq = 0; sw_irq = 0;

      // ebreak over ecall, mode 2 falls back to direct
      mtvec = 64'h8000_2002;
      commit(64'h8000_0404, 1, 1, 0, 0, 32'h0);
      trap_seq("ebreak", 64'd3, 64'h8000_0404, 64'h8000_0404, 64'h8000_2000, 0, 4'd0, 0, 0);

      // mret: target is mepc_in with low bits cleared, redirect held 3 cycles
      mepc_in = 64'h8000_0203;
      commit(64'h8000_0500, 0, 0, 0, 1, 32'h0);
      mepc_in = 64'h1234_5678;
      trap_seq("mret", 64'd0, 64'd0, 64'd0, 64'h8000_0200, 1, 4'd0, 0, 2);

      // reset in FLUSH aborts, then a fresh ecall completes
      mtvec = 64'h8000_1000;
      commit(64'h8000_0600, 1, 0, 0, 0, 32'h0);
      chk("abort.pre", flush_req, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort.flush_req", flush_req, 0);
      chk("abort.busy", busy, 0);
      chk("abort.csr_we", csr_we, 0);
      chk("abort.redir_valid", redirect_valid, 0);
      chk("abort.mcause", trap_mcause, 0);
      rst = 1'b0;
      @(negedge clk);
      commit(64'h8000_0700, 1, 0, 0, 0, 32'h0);
      trap_seq("post_rst", 64'd11, 64'h8000_0700, 64'd0, 64'h8000_1000, 0, 4'd0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
